// File: rtl/tc_delay_fifo.sv
// First-word-fall-through elastic buffer behind the non-stallable delay line.
// Words arriving while full (and not draining) are dropped and latch a sticky overflow flag.
module tc_delay_fifo #(
  parameter int BIT_WIDTH = 1,
  parameter int DEPTH     = 4,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [BIT_WIDTH-1:0] in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BIT_WIDTH-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        count,
  output logic                 overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BIT_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_overflow;

  logic w_push;
  logic w_pop;
  logic w_drop;
  logic w_not_full;

  // A full queue still accepts a word when the consumer drains the head this cycle.
  assign w_not_full = (r_count < CW'(DEPTH));
  assign in_ready   = w_not_full | out_ready;
  assign out_valid  = (r_count != '0);
  assign w_push     = in_valid & in_ready;
  assign w_pop      = out_valid & out_ready;
  assign w_drop     = in_valid & ~in_ready;

  assign out      = out_valid ? r_mem[r_rd_ptr] : '0;
  assign count    = r_count;
  assign overflow = r_overflow;

  // Storage needs no reset; pointers/count define what is visible.
  always_ff @(posedge clk) begin
    if (rst && !flush && w_push)
      r_mem[r_wr_ptr] <= in;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

endmodule
